// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter/receiver FSM state encoding
package uart_pkg;
   localparam int OVERSAMPLE  = 16;
   localparam int DEF_DBIT    = 8;
   localparam int DEF_SB_TICK = 16;
   localparam int DEF_DVSR    = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } uart_state_e;

   // Bits needed to count 0..max_val, never fewer than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - valid/ready byte handshake into the buffered transmitter
interface uart_tx_buffered_if
   import uart_pkg::*;
#(
   parameter int DBIT = DEF_DBIT
);
   logic [DBIT-1:0] i_tx_data;
   logic            i_tx_valid;
   logic            o_tx_ready;

   modport master (output i_tx_data, output i_tx_valid, input o_tx_ready);
   modport slave  (input i_tx_data, input i_tx_valid, output o_tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversampling tick generator, one tick every DVSR clocks
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DVSR = DEF_DVSR
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clr,
   output logic o_tick
);
   localparam int            CW   = cnt_w(DVSR - 1);
   localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (i_clr || cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = !i_clr && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter, LSB first, 16x tick timing
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK,
   parameter int DVSR    = DEF_DVSR,
   parameter int FIFO_AW = 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   uart_tx_buffered_if.slave    tx_if,
   output logic                 o_tx,
   output logic                 o_tx_busy,
   output logic                 o_tx_done_tick,
   output logic [FIFO_AW:0]     o_fifo_count
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int SW    = cnt_w(((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE) - 1);
   localparam int NW    = cnt_w(DBIT - 1);

   localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
   localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);

   logic [DBIT-1:0]    mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               push, pop, empty, full;

   uart_state_e        state_q, state_d;
   logic [SW-1:0]      s_q, s_d;
   logic [NW-1:0]      n_q, n_d;
   logic [DBIT-1:0]    b_q, b_d;
   logic               tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic               tick, baud_clr;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = tx_if.i_tx_valid && !full;

   // Baud counter sits at zero while idle so a new frame always gets full-length bits.
   assign baud_clr = (state_q == ST_IDLE);

   uart_baud_gen #(.DVSR(DVSR)) u_baud (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (baud_clr),
      .o_tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      pop     = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               b_d     = mem_q[rd_ptr_q];
               s_d     = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = ST_DATA;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (s_q == S_STOP_LAST) begin
                  done_d = 1'b1;
                  s_d    = '0;
                  // Chain straight into the next start bit when more data is waiting.
                  if (!empty) begin
                     pop     = 1'b1;
                     b_d     = mem_q[rd_ptr_q];
                     state_d = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = b_q[0];
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_q != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_if.i_tx_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         s_q      <= '0;
         n_q      <= '0;
         b_q      <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         n_q      <= n_d;
         b_q      <= b_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign tx_if.o_tx_ready = !full;
   assign o_tx             = tx_q;
   assign o_tx_busy        = busy_q;
   assign o_tx_done_tick   = done_q;
   assign o_fifo_count     = count_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed checks of framing, latency, FIFO and reset behaviour
module tb_uart_tx_buffered;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_buffered_if #(.DBIT(8)) tx_if ();
   uart_tx_buffered_if #(.DBIT(8)) tx_if32 ();

   logic       o_tx, o_tx_busy, o_tx_done_tick;
   logic [2:0] o_fifo_count;
   logic       o_tx32, o_tx_busy32, o_tx_done_tick32;
   logic [2:0] o_fifo_count32;

   uart_tx_buffered #(.DBIT(8), .SB_TICK(16), .DVSR(5), .FIFO_AW(2)) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .tx_if          (tx_if),
      .o_tx           (o_tx),
      .o_tx_busy      (o_tx_busy),
      .o_tx_done_tick (o_tx_done_tick),
      .o_fifo_count   (o_fifo_count)
   );

   uart_tx_buffered #(.DBIT(8), .SB_TICK(32), .DVSR(5), .FIFO_AW(2)) dut32 (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .tx_if          (tx_if32),
      .o_tx           (o_tx32),
      .o_tx_busy      (o_tx_busy32),
      .o_tx_done_tick (o_tx_done_tick32),
      .o_fifo_count   (o_fifo_count32)
   );

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // line bits, bit 0 = start bit, bit 9 = stop bit
   } vec_t;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0] push_data [8];
   int         push_edge [8];
   logic       push_acc  [8];

   int          fall_at, done_cnt, busy_drop_at;
   int          done_at [8];
   logic [63:0] line_bits;
   logic        tx_after_done;
   logic [2:0]  cnt_hist [4096];
   logic        rdy_hist [4096];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin
         tx_if32.i_tx_valid = v;
         tx_if32.i_tx_data  = d;
      end else begin
         tx_if.i_tx_valid = v;
         tx_if.i_tx_data  = d;
      end
   endtask

   // Called at a negedge; the following posedge is edge 0 of push_edge[].
   task automatic drive(input int n, input bit sel);
      int i = 0;
      int e = 0;
      while (i < n) begin
         bit   now;
         logic rdy;
         now = (push_edge[i] == e);
         set_in(sel, now, push_data[i]);
         rdy = sel ? tx_if32.o_tx_ready : tx_if.o_tx_ready;
         @(posedge clk);
         if (now) begin
            push_acc[i] = rdy;
            i++;
         end
         e++;
         @(negedge clk);
      end
      set_in(sel, 1'b0, 8'h00);
   endtask

   // Cycle c = negedge after edge c; bit k of the stream is sampled mid-bit at c = 42 + 80k.
   task automatic watch(input int ncyc, input bit sel);
      logic       tx, busy, done, rdy;
      logic [2:0] cnt;
      fall_at = -1; done_cnt = 0; busy_drop_at = -1; line_bits = '0; tx_after_done = 1'b1;
      for (int j = 0; j < 8; j++) done_at[j] = -1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         tx   = sel ? o_tx32 : o_tx;
         busy = sel ? o_tx_busy32 : o_tx_busy;
         done = sel ? o_tx_done_tick32 : o_tx_done_tick;
         rdy  = sel ? tx_if32.o_tx_ready : tx_if.o_tx_ready;
         cnt  = sel ? o_fifo_count32 : o_fifo_count;
         if (fall_at < 0 && !tx) fall_at = c;
         if (c >= 42 && (c - 42) % 80 == 0 && (c - 42) / 80 < 64) line_bits[(c - 42) / 80] = tx;
         if (done_cnt == 1 && done_at[0] == c - 1) tx_after_done = tx;
         if (done) begin
            if (done_cnt < 8) done_at[done_cnt] = c;
            done_cnt++;
         end
         if (busy_drop_at < 0 && c > 2 && !busy) busy_drop_at = c;
         if (c < 4096) begin
            cnt_hist[c] = cnt;
            rdy_hist[c] = rdy;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [4];
      logic [9:0] exp_frames [5];
      int         lows;

      vecs[0] = '{data: 8'h55, frame: 10'h2AA};
      vecs[1] = '{data: 8'h00, frame: 10'h200};
      vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
      vecs[3] = '{data: 8'h80, frame: 10'h300};

      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 8'h00);
      set_in(1'b1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      check("reset_tx", o_tx, 1);
      check("reset_ready", tx_if.o_tx_ready, 1);
      check("reset_count", o_fifo_count, 0);
      check("reset_busy", o_tx_busy, 0);
      check("reset_done", o_tx_done_tick, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frames from the table.
      for (int i = 0; i < 4; i++) begin
         push_data[0] = vecs[i].data;
         push_edge[0] = 0;
         fork
            drive(1, 1'b0);
            watch(810, 1'b0);
         join
         check($sformatf("vec%0d_frame", i), line_bits[9:0], vecs[i].frame);
         check($sformatf("vec%0d_fall_latency", i), fall_at, 2);
         check($sformatf("vec%0d_done_at", i), {done_cnt[7:0], done_at[0][15:0]}, {8'd1, 16'd801});
         check($sformatf("vec%0d_busy_drop", i), busy_drop_at, 802);
      end

      // Back-to-back frames with no idle clock between them.
      push_data[0] = 8'hA5; push_edge[0] = 0;
      push_data[1] = 8'h3C; push_edge[1] = 1;
      fork
         drive(2, 1'b0);
         watch(1610, 1'b0);
      join
      check("b2b_frame0", line_bits[9:0], 10'h34A);
      check("b2b_frame1", line_bits[19:10], 10'h278);
      check("b2b_done_cnt", done_cnt, 2);
      check("b2b_done0", done_at[0], 801);
      check("b2b_done1", done_at[1], 1601);
      check("b2b_start_after_done", tx_after_done, 0);
      check("b2b_busy_drop", busy_drop_at, 1602);

      // Fill the FIFO; the sixth push meets ready low and must be dropped.
      push_data[0] = 8'h0F; push_data[1] = 8'hF0; push_data[2] = 8'h5A;
      push_data[3] = 8'h69; push_data[4] = 8'h96; push_data[5] = 8'hE7;
      for (int i = 0; i < 6; i++) push_edge[i] = i;
      exp_frames[0] = 10'h21E; exp_frames[1] = 10'h3E0; exp_frames[2] = 10'h2B4;
      exp_frames[3] = 10'h2D2; exp_frames[4] = 10'h32C;
      fork
         drive(6, 1'b0);
         watch(4010, 1'b0);
      join
      check("fill_count_full", cnt_hist[4], 4);
      check("fill_ready_low", rdy_hist[4], 0);
      check("fill_extra_rejected", push_acc[5], 0);
      check("fill_count_after_extra", cnt_hist[5], 4);
      for (int j = 0; j < 5; j++)
         check($sformatf("fill_frame%0d", j), line_bits[10*j +: 10], exp_frames[j]);
      check("fill_done_cnt", done_cnt, 5);
      check("fill_busy_drop", busy_drop_at, 4002);

      // Push lands on the same edge as the STOP->START pop with two entries queued.
      push_data[0] = 8'h11; push_edge[0] = 0;
      push_data[1] = 8'h22; push_edge[1] = 1;
      push_data[2] = 8'h33; push_edge[2] = 2;
      push_data[3] = 8'h44; push_edge[3] = 801;
      exp_frames[0] = 10'h222; exp_frames[1] = 10'h244;
      exp_frames[2] = 10'h266; exp_frames[3] = 10'h288;
      fork
         drive(4, 1'b0);
         watch(3210, 1'b0);
      join
      check("simul_count_before", cnt_hist[800], 2);
      check("simul_count_after", cnt_hist[801], 2);
      check("simul_count_next", cnt_hist[802], 2);
      for (int j = 0; j < 4; j++)
         check($sformatf("simul_frame%0d", j), line_bits[10*j +: 10], exp_frames[j]);
      check("simul_done_cnt", done_cnt, 4);

      // Two stop bits: stop lasts 160 clocks, frame 880 clocks.
      push_data[0] = 8'hA5; push_edge[0] = 0;
      fork
         drive(1, 1'b1);
         watch(900, 1'b1);
      join
      check("sb32_frame", line_bits[9:0], 10'h34A);
      check("sb32_done_at", done_at[0], 881);
      check("sb32_busy_drop", busy_drop_at, 882);

      // Asynchronous reset in the middle of a data bit discards the buffered bytes.
      for (int i = 0; i < 3; i++) begin
         push_data[i] = 8'h00;
         push_edge[i] = i;
      end
      drive(3, 1'b0);
      repeat (300) @(negedge clk);
      check("midrst_line_low", o_tx, 0);
      check("midrst_count_pre", o_fifo_count, 2);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_tx_async", o_tx, 1);
      check("midrst_count", o_fifo_count, 0);
      check("midrst_busy", o_tx_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!o_tx || o_tx_busy || o_fifo_count != 0) lows++;
      end
      check("midrst_stays_idle", lows, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
